// File: rtl/byte_serializer.sv
// Byte FIFO + MSB-first serializer feeding the bit-serial pattern detector; frames leave gapless.
// Optional 9th even-parity bit per frame when BYTE_SERIALIZER_PARITY_EN is defined.
module byte_serializer #(
  parameter int   DEPTH    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       ser_out,
  output logic                       ser_valid,
  output logic                       ser_par,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [15:0]                bytes_sent
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef BYTE_SERIALIZER_PARITY_EN
  localparam logic [3:0] LAST_BIT = 4'd8;
`else
  localparam logic [3:0] LAST_BIT = 4'd7;
`endif

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  state_t        r_state;
  logic [7:0]    r_shreg;
  logic [3:0]    r_bit_cnt;
  logic          r_ser_out;
  logic          r_ser_valid;
  logic          r_ser_par;
  logic          r_last;
  logic [15:0]   r_bytes_sent;
`ifdef BYTE_SERIALIZER_PARITY_EN
  logic          r_par;
`endif

  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_head;

  assign in_ready = (r_level < LW'(DEPTH));
  assign w_push   = in_valid && in_ready;
  assign w_head   = r_mem[r_rd_ptr];
  // Pop when idle, or on the last frame bit so the next frame follows with no gap.
  assign w_pop    = (r_level != '0) &&
                    ((r_state == S_IDLE) || (r_bit_cnt == LAST_BIT));

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_ser_out    <= IDLE_BIT;
      r_ser_valid  <= 1'b0;
      r_ser_par    <= 1'b0;
      r_last       <= 1'b0;
      r_bytes_sent <= '0;
`ifdef BYTE_SERIALIZER_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else begin
      r_ser_out   <= IDLE_BIT;
      r_ser_valid <= 1'b0;
      r_ser_par   <= 1'b0;
      r_last      <= 1'b0;
      // The count moves on the edge that ends the frame's final bit cycle.
      if (r_last) r_bytes_sent <= r_bytes_sent + 16'd1;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shreg   <= w_head;
            r_bit_cnt <= '0;
            r_state   <= S_SHIFT;
`ifdef BYTE_SERIALIZER_PARITY_EN
            r_par     <= ^w_head;
`endif
          end
        end
        S_SHIFT: begin
          r_ser_valid <= 1'b1;
          r_ser_out   <= r_shreg[7];
          r_shreg     <= {r_shreg[6:0], 1'b0};
          r_bit_cnt   <= r_bit_cnt + 4'd1;
`ifdef BYTE_SERIALIZER_PARITY_EN
          if (r_bit_cnt == 4'd8) begin
            r_ser_out <= r_par;
            r_ser_par <= 1'b1;
          end
`endif
          if (r_bit_cnt == LAST_BIT) begin
            r_last <= 1'b1;
            if (w_pop) begin
              r_shreg   <= w_head;
              r_bit_cnt <= '0;
`ifdef BYTE_SERIALIZER_PARITY_EN
              r_par     <= ^w_head;
`endif
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ser_out    = r_ser_out;
  assign ser_valid  = r_ser_valid;
  assign ser_par    = r_ser_par;
  assign busy       = (r_state == S_SHIFT);
  assign fifo_level = r_level;
  assign bytes_sent = r_bytes_sent;

endmodule

// File: tb/tb_byte_serializer.sv
// Self-checking bench for byte_serializer: directed scenarios plus randomized traffic
// scored against a frame-level model (accepted bytes -> expected MSB-first bit stream).
module tb_byte_serializer;
  localparam int   DEPTH    = 4;
  localparam logic IDLE_BIT = 1'b0;
`ifdef BYTE_SERIALIZER_PARITY_EN
  localparam int   FL = 9;
`else
  localparam int   FL = 8;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        ser_out;
  logic        ser_valid;
  logic        ser_par;
  logic        busy;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [15:0] bytes_sent;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  bit mon_bits[$];
  bit mon_par[$];
  int mon_cyc[$];

  byte_serializer #(.DEPTH(DEPTH), .IDLE_BIT(IDLE_BIT)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ser_out(ser_out), .ser_valid(ser_valid), .ser_par(ser_par), .busy(busy),
    .fifo_level(fifo_level), .bytes_sent(bytes_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && ser_valid) begin
      mon_bits.push_back(ser_out);
      mon_par.push_back(ser_par);
      mon_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    mon_bits.delete();
    mon_par.delete();
    mon_cyc.delete();
  endtask

  // Bit i of a frame: data MSB first, then the even-parity bit.
  function automatic logic exp_bit(logic [7:0] b, int i);
    if (i < 8) return b[7-i];
    return ^b;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (ser_out !== IDLE_BIT) begin n_bad++; $display("FAIL reset_ser_out got=%b exp=%b", ser_out, IDLE_BIT); end
    n_cmp++; if (ser_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ser_valid got=%b exp=0", ser_valid); end
    n_cmp++; if (ser_par !== 1'b0) begin n_bad++; $display("FAIL reset_ser_par got=%b exp=0", ser_par); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (fifo_level !== '0) begin n_bad++; $display("FAIL reset_fifo_level got=%0d exp=0", fifo_level); end
    n_cmp++; if (bytes_sent !== 16'd0) begin n_bad++; $display("FAIL reset_bytes_sent got=%0d exp=0", bytes_sent); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int nbits = 0;
    int guard = 0;
    mon_clear();
    in_data = 8'hF0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    while (nbits < 3 && guard < 20) begin
      tick(); guard++;
      if (ser_valid) nbits++;
    end
    n_cmp++; if (nbits != 3) begin n_bad++; $display("FAIL midrst_wait got=%0d bits exp=3", nbits); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (ser_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_ser_valid got=%b exp=0", ser_valid); end
    n_cmp++; if (fifo_level !== '0) begin n_bad++; $display("FAIL midrst_fifo_level got=%0d exp=0", fifo_level); end
    n_cmp++; if (bytes_sent !== 16'd0) begin n_bad++; $display("FAIL midrst_bytes_sent got=%0d exp=0", bytes_sent); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    repeat (12) tick();
    n_cmp++; if (ser_valid !== 1'b0 || bytes_sent !== 16'd0) begin
      n_bad++; $display("FAIL midrst_stays_idle got valid=%b sent=%0d exp valid=0 sent=0", ser_valid, bytes_sent);
    end
  endtask

  task automatic test_single();
    logic [15:0] base;
    int e;
    mon_clear();
    base = bytes_sent;
    in_data = 8'hAA; in_valid = 1'b1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready got=%b exp=1", in_ready); end
    tick();
    e = cyc;
    in_valid = 1'b0;
    n_cmp++; if (ser_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid got=%b exp=0", ser_valid); end
    repeat (FL + 1) tick();
    n_cmp++; if (bytes_sent !== base) begin n_bad++; $display("FAIL single_sent_early got=%0d exp=%0d", bytes_sent, base); end
    tick();
    n_cmp++; if (bytes_sent !== 16'(base + 16'd1)) begin n_bad++; $display("FAIL single_sent got=%0d exp=%0d", bytes_sent, base + 16'd1); end
    n_cmp++; if (ser_valid !== 1'b0 || ser_out !== IDLE_BIT) begin
      n_bad++; $display("FAIL single_idle got valid=%b out=%b exp valid=0 out=%b", ser_valid, ser_out, IDLE_BIT);
    end
    n_cmp++; if (mon_bits.size() != FL) begin n_bad++; $display("FAIL single_len got=%0d exp=%0d", mon_bits.size(), FL); end
    else begin
      n_cmp++; if (mon_cyc[0] != e + 2) begin n_bad++; $display("FAIL single_latency got=%0d exp=%0d", mon_cyc[0] - e, 2); end
      for (int i = 0; i < FL; i++) begin
        n_cmp++;
        if (mon_bits[i] !== exp_bit(8'hAA, i) || mon_par[i] !== (i == 8) || mon_cyc[i] != mon_cyc[0] + i) begin
          n_bad++; $display("FAIL single_bit%0d got=%b/par%b exp=%b/par%b", i, mon_bits[i], mon_par[i], exp_bit(8'hAA, i), (i == 8));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    logic [15:0] base;
    mon_clear();
    base = bytes_sent;
    for (int k = 0; k < 4; k++) begin
      in_data = pat[k]; in_valid = 1'b1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready%0d got=%b exp=1", k, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    repeat (4 * FL + 6) tick();
    n_cmp++; if (bytes_sent !== 16'(base + 16'd4)) begin n_bad++; $display("FAIL b2b_sent got=%0d exp=%0d", bytes_sent, base + 16'd4); end
    n_cmp++; if (mon_bits.size() != 4 * FL) begin n_bad++; $display("FAIL b2b_len got=%0d exp=%0d", mon_bits.size(), 4 * FL); end
    else begin
      for (int i = 0; i < 4 * FL; i++) begin
        n_cmp++;
        if (mon_bits[i] !== exp_bit(pat[i / FL], i % FL) || mon_cyc[i] != mon_cyc[0] + i) begin
          n_bad++; $display("FAIL b2b_bit%0d got=%b cyc+%0d exp=%b cyc+%0d", i, mon_bits[i], mon_cyc[i] - mon_cyc[0], exp_bit(pat[i / FL], i % FL), i);
        end
      end
    end
  endtask

  task automatic test_fill();
    logic [7:0] acc[$];
    logic [15:0] base;
    int guard = 0;
    mon_clear();
    base = bytes_sent;
    for (int k = 0; k < 12; k++) begin
      in_data = 8'($urandom); in_valid = 1'b1;
      if (k < 5) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready%0d got=%b exp=1", k, in_ready); end
      end
      if (k == 5) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_full got=%b exp=0", in_ready); end
      end
      if (in_ready) acc.push_back(in_data);
      tick();
    end
    in_valid = 1'b0;
    while (mon_bits.size() < acc.size() * FL && guard < 300) begin tick(); guard++; end
    repeat (4) tick();
    n_cmp++; if (mon_bits.size() != acc.size() * FL) begin n_bad++; $display("FAIL fill_len got=%0d exp=%0d", mon_bits.size(), acc.size() * FL); end
    else begin
      for (int i = 0; i < acc.size() * FL; i++) begin
        n_cmp++;
        if (mon_bits[i] !== exp_bit(acc[i / FL], i % FL)) begin
          n_bad++; $display("FAIL fill_bit%0d got=%b exp=%b", i, mon_bits[i], exp_bit(acc[i / FL], i % FL));
        end
      end
    end
    n_cmp++; if (bytes_sent !== 16'(base + 16'(acc.size()))) begin n_bad++; $display("FAIL fill_sent got=%0d exp=%0d", bytes_sent, base + 16'(acc.size())); end
  endtask

  task automatic test_random();
    logic [7:0] acc[$];
    logic [15:0] base;
    int guard = 0;
    mon_clear();
    base = bytes_sent;
    for (int k = 0; k < 150; k++) begin
      in_data = 8'($urandom); in_valid = 1'($urandom_range(0, 1));
      n_cmp++; if (in_ready !== (fifo_level < DEPTH) || fifo_level > DEPTH) begin
        n_bad++; $display("FAIL rand_ready%0d got ready=%b level=%0d exp ready=(level<%0d)", k, in_ready, fifo_level, DEPTH);
      end
      if (in_valid && in_ready) acc.push_back(in_data);
      tick();
    end
    in_valid = 1'b0;
    while (mon_bits.size() < acc.size() * FL && guard < 400) begin tick(); guard++; end
    repeat (4) tick();
    n_cmp++; if (mon_bits.size() != acc.size() * FL) begin n_bad++; $display("FAIL rand_len got=%0d exp=%0d", mon_bits.size(), acc.size() * FL); end
    else begin
      for (int i = 0; i < acc.size() * FL; i++) begin
        n_cmp++;
        if (mon_bits[i] !== exp_bit(acc[i / FL], i % FL) || mon_par[i] !== ((i % FL) == 8)) begin
          n_bad++; $display("FAIL rand_bit%0d got=%b/par%b exp=%b/par%b", i, mon_bits[i], mon_par[i], exp_bit(acc[i / FL], i % FL), ((i % FL) == 8));
        end
      end
    end
    n_cmp++; if (bytes_sent !== 16'(base + 16'(acc.size()))) begin n_bad++; $display("FAIL rand_sent got=%0d exp=%0d", bytes_sent, base + 16'(acc.size())); end
    n_cmp++; if (fifo_level !== '0 || busy !== 1'b0) begin n_bad++; $display("FAIL rand_drained got level=%0d busy=%b exp 0/0", fifo_level, busy); end
  endtask

`ifdef BYTE_SERIALIZER_PARITY_EN
  task automatic test_parity();
    logic [8:0] exp_frame = 9'b0_0000_0111_1;
    mon_clear();
    in_data = 8'h07; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (FL + 4) tick();
    n_cmp++; if (mon_bits.size() != 9) begin n_bad++; $display("FAIL par_len got=%0d exp=9", mon_bits.size()); end
    else begin
      for (int i = 0; i < 9; i++) begin
        n_cmp++;
        if (mon_bits[i] !== exp_frame[8-i] || mon_par[i] !== (i == 8)) begin
          n_bad++; $display("FAIL par_bit%0d got=%b/par%b exp=%b/par%b", i, mon_bits[i], mon_par[i], exp_frame[8-i], (i == 8));
        end
      end
    end
  endtask
`else
  task automatic test_detector();
    logic [7:0] sh = 8'h00;
    int first = -1;
    mon_clear();
    in_data = 8'hAA; in_valid = 1'b1;
    tick();
    in_data = 8'hAB;
    tick();
    in_valid = 1'b0;
    repeat (2 * FL + 6) tick();
    // Detector for 8'h55: a match needs a full 8-bit window of stream bits.
    for (int i = 0; i < mon_bits.size(); i++) begin
      sh = {sh[6:0], mon_bits[i]};
      if (i >= 7 && sh == 8'h55 && first < 0) first = i;
    end
    n_cmp++; if (first != 8) begin n_bad++; $display("FAIL detector_match got=%0d exp=8", first); end
    n_cmp++; if (mon_bits.size() != 16 || mon_cyc[mon_cyc.size()-1] != mon_cyc[0] + 15) begin
      n_bad++; $display("FAIL detector_gapless got=%0d bits exp=16 contiguous", mon_bits.size());
    end
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    test_reset();
    test_reset_midframe();
    test_single();
    test_back_to_back();
    test_fill();
    test_random();
`ifdef BYTE_SERIALIZER_PARITY_EN
    test_parity();
`else
    test_detector();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
